add_sub4: RTL and testbench
===========================

// Module: add_sub4
// PURPOSE
//   4-bit two's-complement adder/subtractor with registered outputs.
//   op=0 computes a+b; op=1 computes a-b as a + ~b + 1 through a shared ripple-carry adder.
//   Leaf arithmetic block for datapath use; inputs are sampled every clock, with no handshake.
// PARAMETERS
//   none; width is fixed at 4 bits.
// PORTS
//   clk    in   1  single clock; all state updates on the rising edge
//   rst    in   1  reset, asynchronous and active-high
//   op     in   1  0 = add, 1 = subtract
//   a      in   4  signed operand A, two's complement
//   b      in   4  signed operand B, two's complement
//   sum    out  4  signed result, registered
//   c_out  out  1  carry out of bit 3, registered; on subtract, 1 = no borrow
//   ovf    out  1  signed overflow flag, registered
// BEHAVIOUR
//   - Reset: while rst=1, sum=4'b0000, c_out=0, ovf=0, asynchronously. Reset applies immediately,
//     even mid-operation. First capture occurs on the first rising clk edge after rst falls.
//   - Datapath (combinational):
//       bx = b ^ {4{op}}; cin = op;
//       {c4, s} = a + bx + cin   (4 ripple full-adder stages, c0=cin)
//       v = c4 ^ c3   (carry into MSB xor carry out of MSB)
//   - Register: on each posedge clk with rst=0: sum<=s, c_out<=c4, ovf<=v.
//   - Latency is exactly 1 cycle and throughput is 1 result/cycle; op, a and b are used on the
//     same edge, with no pipelining between them.
//   - Width rules:
//       sum wraps modulo 16.
//       c_out is the unsigned carry/not-borrow.
//       ovf=1 iff the true signed result lies outside [-8,7].
//   - Boundaries:
//       a-b with b=0 gives c_out=1.
//       a-(-8) overflows whenever a>=0.
//       -8+-8 gives sum=0, c_out=1, ovf=1.
//   - An op change between edges has no effect until the next edge; outputs never glitch
//     because they come from flops.
//   - No X propagation from reset values. Unknown inputs are not required to be handled.
// STRUCTURE
//   - Sub-module full_adder (a, b, cin -> s, cout); instantiate 4 times in a ripple chain.
//   - The conditional invert (b ^ {4{op}}) and the output register stay in add_sub4.
//   - Shared package: constants OP_ADD=1'b0, OP_SUB=1'b1 and WIDTH=4. No typedefs needed.
// TESTING
//   1. Reset: assert rst mid-run with nonzero outputs -> sum=0, c_out=0, ovf=0 immediately,
//      without a clock edge.
//   2. Add: a=5, b=0, op=0 -> after 1 edge, sum=5, c_out=0, ovf=0.
//   3. Sub no borrow: a=5, b=0, op=1 -> sum=5, c_out=1, ovf=0.
//      a=5, b=3, op=1 -> sum=2, c_out=1.
//   4. Sub borrow: a=5, b=7, op=1 -> sum=4'b1110 (-2), c_out=0, ovf=0.
//   5. Overflow:
//        a=5, b=3, op=0 -> sum=4'b1000 (-8), c_out=0, ovf=1.
//        a=5, b=-8, op=1 -> sum=4'b1101, c_out=0, ovf=1.
//        a=-8, b=-8, op=0 -> sum=0, c_out=1, ovf=1.
//   6. Sweep: a=5 with op toggling every cycle and b incrementing 0..15 (wrapping) -> every
//      cycle, sum equals the 1-cycle-delayed golden model (a±b mod 16), and c_out/ovf match.
//      Then run an exhaustive 512-combination check against the model.

Source files
------------

// File: rtl/add_sub4_pkg.sv
// Shared constants for the 4-bit adder/subtractor.
package add_sub4_pkg;

    localparam int unsigned WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; one stage of the add_sub4 ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/add_sub4.sv
// 4-bit two's-complement adder/subtractor with registered sum, carry and overflow.
module add_sub4
    import add_sub4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    logic             v;

    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    // Subtract reuses the adder: a - b = a + ~b + 1, the +1 entering as carry-in.
    always_comb begin
        bx   = (op == OP_ADD) ? b : ~b;
        c[0] = (op == OP_SUB);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (a[i]),
            .b    (bx[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    always_comb begin
        v = c[WIDTH] ^ c[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= s;
            c_out_q <= c[WIDTH];
            ovf_q   <= v;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_add_sub4.sv
// Self-checking bench for add_sub4: vector table, corner sequences, sweep and exhaustive check.
module tb_add_sub4;
    import add_sub4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       c_out;
    logic       ovf;

    typedef struct {
        logic [3:0] sum;
        logic       c;
        logic       v;
    } exp_t;

    typedef struct {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;

    add_sub4 dut (
        .clk   (clk),
        .rst   (rst),
        .op    (op),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Integer reference: signed result for overflow, unsigned result for carry/not-borrow.
    function automatic exp_t model(logic o, logic [3:0] x, logic [3:0] y);
        exp_t m;
        int   sx;
        int   sy;
        int   res;
        int   ures;
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        res  = o ? (sx - sy) : (sx + sy);
        ures = o ? (int'(x) - int'(y) + 16) : (int'(x) + int'(y));
        m.sum = res[3:0];
        m.c   = (ures >= 16);
        m.v   = (res < -8) || (res > 7);
        return m;
    endfunction

    function automatic exp_t mk(logic [3:0] s, logic cc, logic vv);
        exp_t m;
        m.sum = s;
        m.c   = cc;
        m.v   = vv;
        return m;
    endfunction

    task automatic compare(string name, exp_t e);
        checks++;
        if (sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
            errors++;
            $display("FAIL %s: got sum=%h c_out=%b ovf=%b, expected sum=%h c_out=%b ovf=%b",
                     name, sum, c_out, ovf, e.sum, e.c, e.v);
        end
    endtask

    task automatic pop_check(string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got sum=%h expected an entry", name, sum);
        end else begin
            e = exp_q.pop_front();
            compare(name, e);
        end
    endtask

    task automatic apply_exp(logic o, logic [3:0] x, logic [3:0] y, exp_t e, string name);
        @(negedge clk);
        op = o;
        a  = x;
        b  = y;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    task automatic apply(logic o, logic [3:0] x, logic [3:0] y, string name);
        apply_exp(o, x, y, model(o, x, y), name);
    endtask

    initial begin
        tbl[0] = '{OP_ADD, 4'd5, 4'd0,  mk(4'd5,  1'b0, 1'b0)};
        tbl[1] = '{OP_SUB, 4'd5, 4'd0,  mk(4'd5,  1'b1, 1'b0)};
        tbl[2] = '{OP_SUB, 4'd5, 4'd3,  mk(4'd2,  1'b1, 1'b0)};
        tbl[3] = '{OP_SUB, 4'd5, 4'd7,  mk(4'he,  1'b0, 1'b0)};
        tbl[4] = '{OP_ADD, 4'd5, 4'd3,  mk(4'h8,  1'b0, 1'b1)};
        tbl[5] = '{OP_SUB, 4'd5, 4'h8,  mk(4'hd,  1'b0, 1'b1)};
        tbl[6] = '{OP_ADD, 4'h8, 4'h8,  mk(4'h0,  1'b1, 1'b1)};
        tbl[7] = '{OP_SUB, 4'd0, 4'd0,  mk(4'h0,  1'b1, 1'b0)};
        tbl[8] = '{OP_SUB, 4'h8, 4'd1,  mk(4'h7,  1'b1, 1'b1)};
        tbl[9] = '{OP_ADD, 4'd7, 4'd1,  mk(4'h8,  1'b0, 1'b1)};

        rst = 1'b1;
        op  = OP_ADD;
        a   = 4'd0;
        b   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_hold", mk(4'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply_exp(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Outputs hold between edges even when op changes.
        apply(OP_ADD, 4'd5, 4'd3, "pre_opchg");
        #1;
        op = OP_SUB;
        #1;
        compare("op_change_hold", mk(4'h8, 1'b0, 1'b1));

        // Asynchronous reset with nonzero outputs, before any further edge.
        rst = 1'b1;
        #1;
        compare("async_reset", mk(4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        compare("reset_edge_hold", mk(4'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        apply(OP_ADD, 4'd5, 4'd0, "first_after_reset");

        for (int i = 0; i < 16; i++) begin
            apply(1'(i % 2), 4'd5, 4'(i), $sformatf("sweep_b%0d", i));
        end

        for (int o = 0; o < 2; o++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    apply(1'(o), 4'(x), 4'(y), $sformatf("exh_op%0d_a%0d_b%0d", o, x, y));
                end
            end
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
